// File: rtl/prbs_gen_check.sv
// PRBS pattern generator and self-aligning checker for link/pad BIST.
// Supports PRBS7/15/23/31 with DATA_W bits per clock. The checker seeds its
// LFSR from the received stream (HUNT), verifies its prediction (CHECK),
// then counts bit errors while LOCKED.
// Reset rst_n is asynchronous and active-high despite its name; it matches the
// existing reset network this block is wired into.
module prbs_gen_check #(
    parameter int          DATA_W   = 1,
    parameter logic [30:0] SEED     = 31'h1,
    parameter int          LOCK_CNT = 32,
    parameter int          LOSS_CNT = 4,
    parameter int          ERR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        poly_sel,
    input  logic              inject_err,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int LOSS_W = $clog2(LOSS_CNT + 1);
    localparam int POP_W  = $clog2(DATA_W + 1);
    localparam int SUM_W  = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} chk_state_e;

    // Active bits of the LFSR for each polynomial length (7/15/23/31).
    function automatic logic [30:0] poly_mask(input logic [1:0] sel);
        case (sel)
            2'd0:    return 31'h0000_007F;
            2'd1:    return 31'h0000_7FFF;
            2'd2:    return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

    // Feedback: XOR of bit N-1 and bit tap-1.
    function automatic logic poly_fb(input logic [30:0] s, input logic [1:0] sel);
        case (sel)
            2'd0:    return s[6]  ^ s[5];
            2'd1:    return s[14] ^ s[13];
            2'd2:    return s[22] ^ s[17];
            default: return s[30] ^ s[27];
        endcase
    endfunction

    // Oldest bit of the register, which is the next generator output bit.
    function automatic logic poly_msb(input logic [30:0] s, input logic [1:0] sel);
        case (sel)
            2'd0:    return s[6];
            2'd1:    return s[14];
            2'd2:    return s[22];
            default: return s[30];
        endcase
    endfunction

    // Number of received words needed to fill N bits of checker state.
    function automatic logic [5:0] fill_words(input logic [1:0] sel);
        int n;
        case (sel)
            2'd0:    n = 7;
            2'd1:    n = 15;
            2'd2:    n = 23;
            default: n = 31;
        endcase
        return 6'((n + DATA_W - 1) / DATA_W);
    endfunction

    logic [1:0]        poly_q;
    logic              poly_chg;
    logic [30:0]       gen_q, gen_d, gen_s;
    logic [DATA_W-1:0] gen_word;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              inj_pend_q, inj_pend_d, inj_now;

    chk_state_e        state_q, state_d;
    logic [30:0]       chk_q, chk_d, chk_s, hunt_s;
    logic [DATA_W-1:0] exp_word, diff;
    logic              word_err;
    logic [POP_W-1:0]  pop;
    logic [SUM_W-1:0]  sum;
    logic [5:0]        fill_q, fill_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              pulse_q, pulse_d;
    logic [ERR_W-1:0]  cnt_q, cnt_d;

    assign poly_chg  = (poly_sel != poly_q);
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign locked    = (state_q == LOCKED);
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;

    // Expand DATA_W generator steps; the oldest bit lands in the word MSB.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gen_s    = gen_q;
        gen_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            gen_word[DATA_W-1-i] = poly_msb(gen_s, poly_q);
            gen_s = {gen_s[29:0], poly_fb(gen_s, poly_q)} & poly_mask(poly_q);
        end
    end

    // Generator next state: advance on en, hold injection until used, reload on poly change.
    always_comb begin
        inj_now    = inject_err | inj_pend_q;
        gen_d      = gen_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = en;
        inj_pend_d = inj_now;
        if (en) begin
            gen_d      = gen_s;
            tx_data_d  = gen_word ^ DATA_W'(inj_now);
            inj_pend_d = 1'b0;
        end
        if (poly_chg) begin
            gen_d = SEED & poly_mask(poly_sel);
        end
    end

    // Checker datapath: shift rx bits in (HUNT) or predict from own state (CHECK/LOCKED).
    always_comb begin
        hunt_s   = chk_q;
        chk_s    = chk_q;
        exp_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            hunt_s = {hunt_s[29:0], rx_data[DATA_W-1-i]} & poly_mask(poly_q);
            exp_word[DATA_W-1-i] = poly_fb(chk_s, poly_q);
            chk_s = {chk_s[29:0], exp_word[DATA_W-1-i]} & poly_mask(poly_q);
        end
        diff     = exp_word ^ rx_data;
        word_err = |diff;
        pop      = POP_W'($countones(diff));
        sum      = SUM_W'(cnt_q) + SUM_W'(pop);
    end

    // Checker FSM next state, lock/loss counters and saturating error count.
    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        fill_d  = fill_q;
        good_d  = good_q;
        loss_d  = loss_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        if (poly_chg) begin
            state_d = HUNT;
            fill_d  = '0;
            good_d  = '0;
            loss_d  = '0;
        end else if (rx_valid) begin
            unique case (state_q)
                HUNT: begin
                    chk_d = hunt_s;
                    if (fill_q == fill_words(poly_q) - 6'd1) begin
                        state_d = CHECK;
                        fill_d  = '0;
                        good_d  = '0;
                    end else begin
                        fill_d = fill_q + 6'd1;
                    end
                end
                CHECK: begin
                    chk_d = chk_s;
                    if (word_err) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        loss_d  = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    chk_d = chk_s;
                    if (word_err) begin
                        pulse_d = 1'b1;
                        cnt_d   = (sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : ERR_W'(sum);
                        if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                        end else begin
                            loss_d = loss_q + LOSS_W'(1);
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    // State registers for generator and checker.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            poly_q     <= 2'd0;
            gen_q      <= SEED & poly_mask(2'd0);
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            inj_pend_q <= 1'b0;
            state_q    <= HUNT;
            chk_q      <= '0;
            fill_q     <= '0;
            good_q     <= '0;
            loss_q     <= '0;
            pulse_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            poly_q     <= poly_sel;
            gen_q      <= gen_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            inj_pend_q <= inj_pend_d;
            state_q    <= state_d;
            chk_q      <= chk_d;
            fill_q     <= fill_d;
            good_q     <= good_d;
            loss_q     <= loss_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prbs_gen_check.sv
// Directed bench for prbs_gen_check: PRBS7 bit-serial generator, PRBS31/15
// byte-wide loopback with lock, injection, loss, saturation and poly change.
module tb_prbs_gen_check;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Bit-serial PRBS7 instance, looped back.
    logic        en1;
    logic [0:0]  tx1;
    logic        txv1, locked1, pulse1;
    logic [15:0] cnt1;

    // Byte-wide instance with default counters, loopback with optional all-ones override.
    logic        en8, inj8, clr8, force_ones;
    logic [1:0]  poly8;
    logic [7:0]  tx8, rx8;
    logic        txv8, locked8, pulse8;
    logic [15:0] cnt8;
    assign rx8 = force_ones ? 8'hFF : tx8;

    // Byte-wide instance with a 4-bit counter and a long loss window.
    logic        ens, clrs;
    logic [7:0]  txs, rxs, masks;
    logic        txvs, lockeds, pulses;
    logic [3:0]  cnts;
    assign rxs = txs ^ masks;

    prbs_gen_check #(.DATA_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .poly_sel(2'd0), .inject_err(1'b0),
        .tx_data(tx1), .tx_valid(txv1), .rx_data(tx1), .rx_valid(txv1), .clr_cnt(1'b0),
        .locked(locked1), .err_pulse(pulse1), .err_count(cnt1)
    );

    prbs_gen_check #(.DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .poly_sel(poly8), .inject_err(inj8),
        .tx_data(tx8), .tx_valid(txv8), .rx_data(rx8), .rx_valid(txv8), .clr_cnt(clr8),
        .locked(locked8), .err_pulse(pulse8), .err_count(cnt8)
    );

    prbs_gen_check #(.DATA_W(8), .ERR_W(4), .LOSS_CNT(1000)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(ens), .poly_sel(2'd3), .inject_err(1'b0),
        .tx_data(txs), .tx_valid(txvs), .rx_data(rxs), .rx_valid(txvs), .clr_cnt(clrs),
        .locked(lockeds), .err_pulse(pulses), .err_count(cnts)
    );

    // Reference bit streams from the polynomial recurrences.
    bit m7  [0:399];
    bit m31 [0:99999];
    bit cap [0:279];

    int widx;
    int cur_idx;
    int exp_cnt;

    typedef struct packed {
        logic en;
        logic exp_bit;
        logic exp_valid;
    } vec_t;
    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next negedge; track which PRBS31 word the byte instance presents.
    task automatic tick();
        @(negedge clk);
        cur_idx = widx;
        if (txv8) widx++;
    endtask

    function automatic logic [7:0] model_word(input int idx);
        logic [7:0] w;
        for (int b = 0; b < 8; b++) w[7-b] = m31[8*idx + b];
        return w;
    endfunction

    function automatic int zeros(input int idx);
        return 8 - $countones(model_word(idx));
    endfunction

    function automatic bit has_ff(input int idx);
        bit r = 1'b0;
        for (int k = 0; k < 4; k++) if (model_word(idx + k) == 8'hFF) r = 1'b1;
        return r;
    endfunction

    task automatic wait_lock8(output int n);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            if (locked8) return;
            if (txv8) n++;
            tick();
        end
        n = -1;
    endtask

    initial begin
        int n;
        int mism;
        int npulse;
        bit got;

        en1 = 1'b1; en8 = 1'b0; inj8 = 1'b0; clr8 = 1'b0; force_ones = 1'b0; poly8 = 2'd3;
        ens = 1'b0; clrs = 1'b0; masks = 8'h00;
        widx = 0; cur_idx = 0; exp_cnt = 0;

        for (int k = 0; k < 7; k++) m7[k] = (k == 6);
        for (int k = 0; k + 7 < 400; k++) m7[k+7] = m7[k] ^ m7[k+1];
        for (int k = 0; k < 31; k++) m31[k] = (k == 30);
        for (int k = 0; k + 31 < 100000; k++) m31[k+31] = m31[k] ^ m31[k+3];

        // {en applied at this negedge, tx bit and tx_valid expected at the next one}
        vecs[0]  = '{1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst tx_data8", 64'(tx8), 64'h0);
        check("rst tx_valid8", 64'(txv8), 64'h0);
        check("rst locked8", 64'(locked8), 64'h0);
        check("rst err_pulse8", 64'(pulse8), 64'h0);
        check("rst err_count8", 64'(cnt8), 64'h0);
        check("rst tx_data1", 64'(tx1), 64'h0);

        // PRBS7 bit-serial: table of first bits with an en pause
        rst_n = 1'b0;
        for (int r = 0; r < 17; r++) begin
            en1 = vecs[r].en;
            tick();
            check($sformatf("prbs7 bit row%0d", r), 64'(tx1), 64'(vecs[r].exp_bit));
            check($sformatf("prbs7 valid row%0d", r), 64'(txv1), 64'(vecs[r].exp_valid));
        end
        en1 = 1'b1;
        mism = 0;
        for (int k = 0; k < 280; k++) begin
            tick();
            cap[k] = tx1[0];
            if (tx1[0] !== m7[15+k] || txv1 !== 1'b1) mism++;
        end
        check("prbs7 stream mismatches", 64'(mism), 64'h0);
        mism = 0;
        for (int k = 0; k + 127 < 280; k++) if (cap[k] != cap[k+127]) mism++;
        check("prbs7 period 127", 64'(mism), 64'h0);
        check("prbs7 loopback locked", 64'(locked1), 64'h1);
        check("prbs7 loopback err_count", 64'(cnt1), 64'h0);

        // Saturation with ERR_W=4: one bit error per word while locked
        ens = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            if (lockeds) got = 1'b1;
        end
        check("sat instance locks", 64'(got), 64'h1);
        masks = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("sat count after %0d", k), 64'(cnts), 64'((k < 15) ? k : 15));
        end
        check("sat err_pulse", 64'(pulses), 64'h1);
        clrs = 1'b1;
        tick();
        check("clr beats error", 64'(cnts), 64'h0);
        clrs = 1'b0;
        tick();
        check("count after clr", 64'(cnts), 64'h1);
        masks = 8'h00;
        tick();
        check("count stable clean", 64'(cnts), 64'h1);
        check("sat stays locked", 64'(lockeds), 64'h1);
        check("sat pulse clears", 64'(pulses), 64'h0);
        ens = 1'b0;

        // PRBS31 byte loopback: lock after 4 fill + 32 good words
        en8 = 1'b1;
        wait_lock8(n);
        check("prbs31 words to lock", 64'(n), 64'd36);
        mism = 0;
        npulse = 0;
        for (int k = 0; k < 10000; k++) begin
            tick();
            if (txv8 && tx8 !== model_word(cur_idx)) mism++;
            if (pulse8) npulse++;
        end
        check("prbs31 tx vs model", 64'(mism), 64'h0);
        check("prbs31 10k err_count", 64'(cnt8), 64'h0);
        check("prbs31 10k err_pulses", 64'(npulse), 64'h0);
        check("prbs31 10k locked", 64'(locked8), 64'h1);

        // Single injected error while enabled
        inj8 = 1'b1;
        tick();
        inj8 = 1'b0;
        check("inject pulse not early", 64'(pulse8), 64'h0);
        tick();
        exp_cnt = 1;
        check("inject err_pulse", 64'(pulse8), 64'h1);
        check("inject err_count", 64'(cnt8), 64'(exp_cnt));
        check("inject still locked", 64'(locked8), 64'h1);
        tick();
        check("inject pulse one clock", 64'(pulse8), 64'h0);

        // Two pulses while en=0 collapse into one error on the next enabled word
        en8 = 1'b0;
        tick();
        inj8 = 1'b1;
        tick();
        inj8 = 1'b0;
        tick();
        inj8 = 1'b1;
        tick();
        inj8 = 1'b0;
        en8 = 1'b1;
        tick();
        check("pending pulse not early", 64'(pulse8), 64'h0);
        tick();
        exp_cnt = 2;
        check("pending err_pulse", 64'(pulse8), 64'h1);
        check("pending err_count", 64'(cnt8), 64'(exp_cnt));
        npulse = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pulse8) npulse++;
        end
        check("pending collapsed", 64'(cnt8), 64'(exp_cnt));
        check("pending no extra pulses", 64'(npulse), 64'h0);

        // All-ones override for 4 words: popcount accumulation and loss of lock
        tick();
        for (int c = 0; c < 100 && has_ff(cur_idx); c++) tick();
        force_ones = 1'b1;
        exp_cnt += zeros(cur_idx);
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("ones count word%0d", j), 64'(cnt8), 64'(exp_cnt));
            check($sformatf("ones locked word%0d", j), 64'(locked8), 64'(j < 3));
            check($sformatf("ones pulse word%0d", j), 64'(pulse8), 64'h1);
            if (j < 3) exp_cnt += zeros(cur_idx);
            else force_ones = 1'b0;
        end
        wait_lock8(n);
        check("relock words", 64'(n), 64'd36);
        check("relock count kept", 64'(cnt8), 64'(exp_cnt));

        // Polynomial change 3 -> 1 while locked
        tick();
        poly8 = 2'd1;
        tick();
        check("poly change drops lock", 64'(locked8), 64'h0);
        tick();
        check("prbs15 word0 from seed", 64'(tx8), 64'h00);
        tick();
        check("prbs15 word1 from seed", 64'(tx8), 64'h02);
        tick();
        check("prbs15 word2 from seed", 64'(tx8), 64'h00);
        wait_lock8(n);
        check("prbs15 relocks", 64'(n >= 0), 64'h1);
        repeat (200) tick();
        check("prbs15 err_count unchanged", 64'(cnt8), 64'(exp_cnt));
        check("prbs15 stays locked", 64'(locked8), 64'h1);

        // Asynchronous reset mid-operation, between clock edges
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("async rst locked", 64'(locked8), 64'h0);
        check("async rst err_count", 64'(cnt8), 64'h0);
        check("async rst tx_valid", 64'(txv8), 64'h0);
        check("async rst tx_data", 64'(tx8), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
